// File: rtl/gray_to_binary_seq.sv
`default_nettype none
// ============================================================================
// Module     : gray_to_binary_seq
// Description: Bit-serial Gray-to-binary converter, one bit per clock, MSB
//              first, with valid/ready handshakes on both sides.
//              Optional Gray-step checker enabled by macro GRAY_STEP_CHECK_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module gray_to_binary_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] G,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] B,
    output logic             step_err
);

    localparam int              IDXW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] IDX_START = IDXW'((WIDTH > 1) ? WIDTH - 2 : 0);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] g_cap;
    logic [WIDTH-1:0] b_step;
    logic [IDXW-1:0]  idx;
    logic             accept;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (WIDTH == 1) ? DONE : CONV;
                end
            end
            CONV: begin
                if (idx == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Resolve only the bit selected by idx; every other bit of B is held.
    if (WIDTH > 1) begin : g_conv
        always_comb begin
            b_step = B;
            for (int k = 0; k < WIDTH - 1; k++) begin
                if (idx == IDXW'(k)) begin
                    b_step[k] = B[k + 1] ^ g_cap[k];
                end
            end
        end
    end else begin : g_single
        assign b_step = B;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            B     <= '0;
            idx   <= '0;
            g_cap <= '0;
        end else if (accept) begin
            g_cap <= G;
            B     <= G & MSB_MASK;
            idx   <= IDX_START;
        end else if (state == CONV) begin
            B <= b_step;
            if (idx != '0) begin
                idx <= idx - 1'b1;
            end
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_word;
    logic             hist_valid;
    logic             step_err_q;

    // An identical consecutive word has popcount 0 and is flagged as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_word  <= '0;
            hist_valid <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            step_err_q <= accept && hist_valid && ($countones(G ^ prev_word) != 1);
            if (accept) begin
                prev_word  <= G;
                hist_valid <= 1'b1;
            end
        end
    end

    assign step_err = step_err_q;
`else
    assign step_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_to_binary_seq.sv
`default_nettype none
// ============================================================================
// Module     : tb_gray_to_binary_seq
// Description: Self-checking bench for gray_to_binary_seq at WIDTH 4, 8 and 1.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_gray_to_binary_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] g;

    logic       act_rdy [3];
    logic       act_vld [3];
    logic       act_err [3];
    logic [7:0] act_b   [3];
    logic       exp_rdy [3];
    logic       exp_vld [3];
    logic       exp_err [3];
    logic [7:0] exp_b   [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Binary value of a Gray word: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [7:0] g2b(input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int s = 0; s < 8; s++) r ^= (x >> s);
        return r;
    endfunction

    function automatic int popcnt(input logic [7:0] x);
        int c;
        c = 0;
        for (int s = 0; s < 8; s++) c += int'(x[s]);
        return c;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int         W    = (i == 0) ? 4 : ((i == 1) ? 8 : 1);
        localparam logic [7:0] MASK = 8'((1 << W) - 1);

        logic         rdy;
        logic         vld;
        logic         err;
        logic [W-1:0] b;

        gray_to_binary_seq #(.WIDTH(W)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (rdy),
            .G        (g[W-1:0]),
            .out_valid(vld),
            .out_ready(out_ready),
            .B        (b),
            .step_err (err)
        );

        logic       m_busy;
        int         m_cnt;
        logic [7:0] m_res;
        logic [7:0] m_b;
        logic       m_err;
`ifdef GRAY_STEP_CHECK_EN
        logic       m_hist;
        logic [7:0] m_prev;
`endif

        // Reference: the top (m_cnt+1) bits of the final result are known m_cnt edges after accept.
        always @(posedge clk) begin
            logic [7:0] gw;
            gw = g & MASK;
            if (rst) begin
                m_busy = 1'b0;
                m_cnt  = 0;
                m_res  = '0;
                m_b    = '0;
                m_err  = 1'b0;
`ifdef GRAY_STEP_CHECK_EN
                m_hist = 1'b0;
                m_prev = '0;
`endif
            end else begin
                m_err = 1'b0;
                if (!m_busy) begin
                    if (in_valid) begin
                        m_busy = 1'b1;
                        m_cnt  = 0;
                        m_res  = g2b(gw);
`ifdef GRAY_STEP_CHECK_EN
                        m_err  = m_hist && (popcnt(gw ^ m_prev) != 1);
                        m_hist = 1'b1;
                        m_prev = gw;
`endif
                    end
                end else if (m_cnt < W - 1) begin
                    m_cnt++;
                end else if (out_ready) begin
                    m_busy = 1'b0;
                end
                if (m_busy) m_b = (m_res >> (W - 1 - m_cnt)) << (W - 1 - m_cnt);
            end
        end

        assign act_rdy[i] = rdy;
        assign act_vld[i] = vld;
        assign act_err[i] = err;
        assign act_b[i]   = 8'(b);
        assign exp_rdy[i] = !m_busy && !rst;
        assign exp_vld[i] = m_busy && (m_cnt == W - 1);
        assign exp_err[i] = m_err;
        assign exp_b[i]   = m_b;
    end

    task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [inst %0d] @%0t: got %h, expected %h", name, inst, $time, act, exp);
        end
    endtask

    task automatic cycle_check();
        for (int i = 0; i < 3; i++) begin
            chk("in_ready",  i, 8'(act_rdy[i]), 8'(exp_rdy[i]));
            chk("out_valid", i, 8'(act_vld[i]), 8'(exp_vld[i]));
            chk("B",         i, act_b[i],       exp_b[i]);
            chk("step_err",  i, 8'(act_err[i]), 8'(exp_err[i]));
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
    endtask

    task automatic send(input logic [7:0] w);
        int n;
        n = 0;
        while (!act_rdy[0] && n < 40) begin
            step();
            n++;
        end
        chk("accept_wait_timeout", 0, 8'(n >= 40), 8'd0);
        in_valid = 1'b1;
        g        = w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int inst, output int n);
        n = 0;
        while (!act_vld[inst] && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int  lat;
        int  seen;
        logic [7:0] gw;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; g = '0;
        step();
        step();
        chk("reset_B",         0, act_b[0],          8'h00);
        chk("reset_out_valid", 0, 8'(act_vld[0]),    8'd0);
        chk("reset_in_ready",  0, 8'(act_rdy[0]),    8'd0);
        rst = 1'b0;
        step();
        chk("ready_after_reset", 0, 8'(act_rdy[0]), 8'd1);

        // All 16 Gray codes in sequence must decode to 0..15.
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            gw = 8'(k ^ (k >> 1));
            send(gw);
            wait_valid(0, lat);
            chk("sweep_latency", 0, 8'(lat), 8'd3);
            chk("sweep_B",       0, act_b[0], 8'(k));
        end
        chk("G1000_to_B1111", 0, act_b[0], 8'b0000_1111);

        // 2-cycle reset in the middle of a conversion.
        send(8'h06);
        rst = 1'b1;
        step();
        step();
        chk("midreset_B",         0, act_b[0],          8'h00);
        chk("midreset_out_valid", 0, 8'(act_vld[0]),    8'd0);
        chk("midreset_step_err",  0, 8'(act_err[0]),    8'd0);
        rst = 1'b0;
        step();
        chk("midreset_ready", 0, 8'(act_rdy[0]), 8'd1);

        // Backpressure: result must hold and further words must be ignored.
        out_ready = 1'b0;
        send(8'h0D);
        wait_valid(0, lat);
        chk("bp_latency", 0, 8'(lat), 8'd3);
        for (int c = 0; c < 5; c++) begin
            in_valid = ~in_valid;
            g        = 8'h05 ^ 8'(c);
            step();
            chk("bp_B",         0, act_b[0],       8'b0000_1001);
            chk("bp_out_valid", 0, 8'(act_vld[0]), 8'd1);
            chk("bp_in_ready",  0, 8'(act_rdy[0]), 8'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_ready", 0, 8'(act_rdy[0]), 8'd1);

        // Reset one edge after accept discards the word.
        send(8'h0F);
        rst = 1'b1;
        step();
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (act_vld[0]) seen = 1;
        end
        chk("conv_reset_no_valid", 0, 8'(seen), 8'd0);
        chk("conv_reset_B",        0, act_b[0], 8'h00);

        // Step checker: only the 0011 -> 0000 transition is a bad step.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] seq [4];
            logic [7:0] want;
            seq[0] = 8'h00; seq[1] = 8'h01; seq[2] = 8'h03; seq[3] = 8'h00;
            want = 8'd0;
`ifdef GRAY_STEP_CHECK_EN
            if (k == 3) want = 8'd1;
`endif
            send(seq[k]);
            chk("step_err_pulse", 0, 8'(act_err[0]), want);
            wait_valid(0, lat);
            chk("step_err_cleared", 0, 8'(act_err[0]), 8'd0);
        end

        // Width corners: all three instances accept 0xFF on the same edge.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        send(8'hFF);
        chk("w1_out_valid", 2, 8'(act_vld[2]), 8'd1);
        chk("w1_B",         2, act_b[2],       8'h01);
        wait_valid(1, lat);
        chk("w8_latency", 1, 8'(lat), 8'd7);
        chk("w8_B",       1, act_b[1], 8'b1010_1010);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_to_binary_seq.md
GRAY_TO_BINARY_SEQ -- requirements
Module: gray_to_binary_seq

Interface
REQ-001 Parameter: WIDTH, default 4, code word width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  a Gray word is present on G.
REQ-005 in_ready  output  1  block can accept a word; high only in IDLE with rst low.
REQ-006 G  input  WIDTH  Gray code word in.
REQ-007 out_valid  output  1  B holds a completed binary result.
REQ-008 out_ready  input  1  consumer accepts B.
REQ-009 B  output  WIDTH  registered binary result.
REQ-010 step_err  output  1  registered Gray-step violation flag (see Configuration).

Function
REQ-011 The FSM SHALL have three states: IDLE, CONV, DONE.
REQ-012 An accept SHALL occur on an edge where in_valid and in_ready are both high.
REQ-013 On accept, the block SHALL capture G, set B[WIDTH-1] = G[WIDTH-1], clear the other B bits, and load bit index WIDTH-2.
REQ-014 On accept with WIDTH>1 the next state SHALL be CONV; with WIDTH=1 it SHALL be DONE.
REQ-015 In CONV, each edge SHALL compute exactly one bit, MSB first: B[i] = B[i+1] XOR Gcap[i], then decrement i.
REQ-016 On the edge that computes bit 0, CONV SHALL go to DONE.
REQ-017 out_valid SHALL be high exactly in DONE, first visible WIDTH-1 edges after the accepting edge (0 for WIDTH=1, i.e. the cycle after accept).
REQ-018 In DONE, B SHALL stay stable until an edge with out_ready high; that edge SHALL return the FSM to IDLE.
REQ-019 in_ready SHALL be low in CONV and DONE; in_valid SHALL be ignored there (no overlap, no buffering).
REQ-020 With out_ready held high, sustained throughput SHALL be one word per WIDTH+1 cycles.
REQ-021 The captured G SHALL not be affected by later changes on G until the next accept.
REQ-022 B SHALL hold its last value in IDLE.

Reset
REQ-023 On an edge with rst high the block SHALL enter IDLE, clear B to 0 and the bit index to 0, drive out_valid=0 and step_err=0, and clear the step-check history.
REQ-024 A reset in CONV or DONE SHALL discard the word in flight; no out_valid SHALL follow for it.
REQ-025 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.

Configuration
REQ-026 Macro GRAY_STEP_CHECK_EN, when defined, SHALL add a previous-word register and a history-valid flag.
REQ-027 With GRAY_STEP_CHECK_EN defined, on each accept with history valid, step_err SHALL pulse high for exactly one cycle after the accepting edge if popcount(G XOR previous) != 1; an equal word also counts as an error.
REQ-028 With GRAY_STEP_CHECK_EN defined, every accept SHALL update the previous-word register and set history valid; the first accept after reset SHALL never flag.
REQ-029 Without GRAY_STEP_CHECK_EN, the step_err port SHALL remain present, be tied to 0, and no history logic SHALL exist.

Verification
REQ-030 Reset: rst high for 2 cycles mid-stream -> B=0000, out_valid=0, step_err=0; in_ready=1 the cycle after release.
REQ-031 Sweep (WIDTH=4, out_ready=1): feed all 16 Gray codes in sequence -> B=0..15 in order, e.g. G=1000 -> B=1111 and G=0110 -> B=0100; out_valid rises exactly 3 edges after each accept.
REQ-032 Backpressure: accept G=1101, hold out_ready=0 for 5 cycles while toggling in_valid -> B=1001 stable, out_valid=1, in_ready=0, no second capture; raise out_ready -> IDLE and in_ready=1 next cycle.
REQ-033 Reset mid-CONV: accept G=1111, assert rst 1 edge later -> out_valid never asserts and B=0000.
REQ-034 Step check with GRAY_STEP_CHECK_EN defined: accept 0000, 0001, 0011, 0000 -> step_err pulses only after the 4th accept; repeat without the macro -> step_err stays 0.
REQ-035 Width corners: WIDTH=8, G=11111111 -> B=10101010 with 7-edge latency; WIDTH=1, G=1 -> B=1 with out_valid the cycle after accept.
